// File: rtl/uart_bridge_pkg.sv
// Shared constants, drain-FSM states and helpers for the UART host bridge.
package uart_bridge_pkg;

  localparam logic [1:0] ADDR_KBD   = 2'd0;
  localparam logic [1:0] ADDR_KBDCR = 2'd1;
  localparam logic [1:0] ADDR_DSP   = 2'd2;
  localparam logic [1:0] ADDR_DSPCR = 2'd3;

  localparam int BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } drainState_t;

  function automatic logic [7:0] toUpper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
  endfunction

endpackage

// File: rtl/uart_host_bridge_if.sv
// CPU bus strobes plus UART receiver/transmitter handshakes seen by the bridge.
interface uart_host_bridge_if;
  logic       cs;
  logic       we;
  logic [1:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (
    output cs, we, address, din, rx_data_ready, rx_data, tx_busy,
    input  dout, tx_start, tx_data
  );

  modport slave (
    input  cs, we, address, din, rx_data_ready, rx_data, tx_busy,
    output dout, tx_start, tx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, combinational head; a pop frees a full slot for a same-cycle push.
// Push when full (without pop) and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic                  doPush;
  logic                  doPop;

  assign empty  = (count == '0);
  assign full   = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign rdata  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/uart_host_bridge.sv
// Apple-1 style KBD/DSP register front end for a UART pair; reads return on dout one cycle later.
// RX overflow drops bytes and sets a sticky flag; full TX drops writes. UART_BRIDGE_UPPERCASE_EN folds a-z to A-Z.
module uart_host_bridge
  import uart_bridge_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input logic              clk,
  input logic              reset,
  uart_host_bridge_if.slave bus
);
  logic        rxEmpty, rxFull, rxPop;
  logic [7:0]  rxHead, rxWdata;
  logic        txEmpty, txFull, txPush, txPop;
  logic [7:0]  txHead;
  logic        busRead, kbdRead, kbdcrRead, overflowEvt, overflow, txIdle;
  logic [7:0]  doutReg;

  drainState_t state, stateNext;
  logic [2:0]  busyCnt, busyCntNext;
  logic        txStartReg, txStartNext;
  logic [7:0]  txDataReg, txDataNext;

  assign busRead     = bus.cs & ~bus.we;
  assign kbdRead     = busRead & (bus.address == ADDR_KBD);
  assign kbdcrRead   = busRead & (bus.address == ADDR_KBDCR);
  assign rxPop       = kbdRead & ~rxEmpty;
  assign overflowEvt = bus.rx_data_ready & rxFull & ~rxPop;
  assign txPush      = bus.cs & bus.we & (bus.address == ADDR_DSP);
  assign txIdle      = txEmpty & (state == IDLE);

`ifdef UART_BRIDGE_UPPERCASE_EN
  assign rxWdata = toUpper(bus.rx_data);
`else
  assign rxWdata = bus.rx_data;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) rxFifo (
    .clk(clk), .reset(reset), .push(bus.rx_data_ready), .pop(rxPop),
    .wdata(rxWdata), .rdata(rxHead), .empty(rxEmpty), .full(rxFull)
  );

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) txFifo (
    .clk(clk), .reset(reset), .push(txPush), .pop(txPop),
    .wdata(bus.din & 8'h7F), .rdata(txHead), .empty(txEmpty), .full(txFull)
  );

  // A same-cycle overflow beats the clear-on-read so the event is never lost.
  always_ff @(posedge clk) begin
    if (reset)            overflow <= 1'b0;
    else if (overflowEvt) overflow <= 1'b1;
    else if (kbdcrRead)   overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      doutReg <= 8'h00;
    end else if (busRead) begin
      case (bus.address)
        ADDR_KBD:   doutReg <= rxEmpty ? 8'h80 : (rxHead | 8'h80);
        ADDR_KBDCR: doutReg <= {~rxEmpty, overflow, 6'b0};
        ADDR_DSP:   doutReg <= {txFull, 7'b0};
        default:    doutReg <= {txIdle, 7'b0};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busyCnt    <= '0;
      txStartReg <= 1'b0;
      txDataReg  <= 8'h00;
    end else begin
      state      <= stateNext;
      busyCnt    <= busyCntNext;
      txStartReg <= txStartNext;
      txDataReg  <= txDataNext;
    end
  end

  always_comb begin
    stateNext   = state;
    busyCntNext = busyCnt;
    txStartNext = 1'b0;
    txDataNext  = txDataReg;
    txPop       = 1'b0;
    case (state)
      IDLE: begin
        if (!txEmpty && !bus.tx_busy) begin
          txDataNext  = txHead;
          txStartNext = 1'b1;
          txPop       = 1'b1;
          busyCntNext = '0;
          stateNext   = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never acknowledges must not stall the queue.
        if (bus.tx_busy)                            stateNext   = WAIT_DONE;
        else if (busyCnt == 3'(BUSY_TIMEOUT - 1))   stateNext   = IDLE;
        else                                        busyCntNext = busyCnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.dout     = doutReg;
  assign bus.tx_start = txStartReg;
  assign bus.tx_data  = txDataReg;
endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: register vector table plus FIFO and drain-FSM sequences.
module tb_uart_host_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_host_bridge_if bus();

  uart_host_bridge dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic       rxv;
    logic [7:0] rxd;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Transmitter model: 0 = busy 10 cycles after start, 1 = never busy, 2 = stuck busy
  int mode = 0;
  int txCnt = 0;
  always @(posedge clk) begin
    if (reset)                        txCnt <= 0;
    else if (bus.tx_start && mode == 0) txCnt <= 10;
    else if (txCnt != 0)              txCnt <= txCnt - 1;
  end
  assign bus.tx_busy = (mode == 2) || (txCnt != 0);

  int cycle = 0;
  int startCount = 0;
  int busyViol = 0;
  int wideViol = 0;
  logic prevStart = 1'b0;
  logic [7:0] startData [64];
  int startCyc [64];
  always @(negedge clk) begin
    cycle++;
    if (bus.tx_start === 1'b1) begin
      if (startCount < 64) begin
        startData[startCount] = bus.tx_data;
        startCyc[startCount]  = cycle;
      end
      startCount++;
      if (bus.tx_busy) busyViol++;
      if (prevStart) wideViol++;
    end
    prevStart = bus.tx_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic cs, input logic we, input logic [1:0] a, input logic [7:0] d,
                     input logic rv, input logic [7:0] rd);
    bus.cs = cs; bus.we = we; bus.address = a; bus.din = d;
    bus.rx_data_ready = rv; bus.rx_data = rd;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; bus.rx_data_ready = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);  cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00); endtask
  task automatic wr(input logic [7:0] d);  cyc(1'b1, 1'b1, 2'd2, d, 1'b0, 8'h00); endtask
  task automatic rx(input logic [7:0] d);  cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic cs, input logic we, input logic [1:0] a, input logic [7:0] d,
                              input logic rv, input logic [7:0] r, input logic c, input logic [7:0] e);
    vec_t v;
    v.cs = cs; v.we = we; v.addr = a; v.din = d; v.rxv = rv; v.rxd = r; v.chk = c; v.exp = e;
    return v;
  endfunction

  vec_t vecs[$];
  logic [7:0] upZ, upA;
  int base;

  initial begin
`ifdef UART_BRIDGE_UPPERCASE_EN
    upZ = 8'hDA; upA = 8'hC1;
`else
    upZ = 8'hFA; upA = 8'hE1;
`endif
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h00, 1, 8'h00));  // KBDCR after reset
    vecs.push_back(mk(1, 0, 3, 0, 0, 8'h00, 1, 8'h80));  // DSPCR idle
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h41, 0, 8'h00));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h00, 1, 8'h80));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 8'hC1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h00, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 8'h80));  // KBD empty
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 8'h80));  // dout holds
    vecs.push_back(mk(1, 0, 2, 0, 0, 8'h00, 1, 8'h00));  // DSP not full
    vecs.push_back(mk(1, 1, 1, 8'h55, 0, 8'h00, 1, 8'h00)); // ignored write, dout holds
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h7A, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, upZ));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h61, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h5B, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h7B, 0, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, upA));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 8'hDB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1, 8'hFB));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h00, 1, 8'h00));

    bus.cs = 0; bus.we = 0; bus.address = 0; bus.din = 0;
    bus.rx_data_ready = 0; bus.rx_data = 0;
    reset = 1'b1;
    @(negedge clk);
    doReset();
    check("reset_dout", bus.dout, 8'h00);
    check("reset_tx_start", bus.tx_start, 1'b0);
    check("reset_tx_data", bus.tx_data, 8'h00);

    foreach (vecs[i]) begin
      cyc(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].rxv, vecs[i].rxd);
      if (vecs[i].chk) check($sformatf("vec%0d", i), bus.dout, vecs[i].exp);
    end
    check("no_start_idle", startCount, 0);

    // 17 pushes into a 16-deep RX FIFO: last byte dropped, overflow sticky until read
    for (int i = 0; i < 17; i++) rx(8'h30 + 8'(i));
    rd(1); check("ovf_set", bus.dout, 8'hC0);
    rd(1); check("ovf_clr", bus.dout, 8'h80);
    for (int i = 0; i < 16; i++) begin
      rd(0); check($sformatf("ovf_kbd%0d", i), bus.dout, 8'hB0 + 8'(i));
    end
    rd(1); check("ovf_drained", bus.dout, 8'h00);
    rd(0); check("ovf_empty", bus.dout, 8'h80);

    // Full FIFO: overflow beats KBDCR clear; a KBD pop lets a same-cycle push in
    for (int i = 0; i < 16; i++) rx(8'h50 + 8'(i));
    cyc(1, 0, 2'd1, 8'h00, 1, 8'h60); check("full_kbdcr_evt", bus.dout, 8'h80);
    rd(1); check("full_ovf_wins", bus.dout, 8'hC0);
    rd(1); check("full_ovf_clr", bus.dout, 8'h80);
    cyc(1, 0, 2'd0, 8'h00, 1, 8'h7F); check("full_pushpop", bus.dout, 8'hD0);
    rd(1); check("full_no_ovf", bus.dout, 8'h80);
    for (int i = 1; i < 16; i++) begin
      rd(0); check($sformatf("full_kbd%0d", i), bus.dout, 8'hD0 + 8'(i));
    end
    rd(0); check("full_last", bus.dout, 8'hFF);
    rd(0); check("full_empty", bus.dout, 8'h80);

    // Normal transmitter: two bytes, second only after busy falls
    mode = 0; base = startCount;
    wr(8'hC8); wr(8'h49);
    rd(3); check("tx_busy_dspcr", bus.dout, 8'h00);
    for (int i = 0; i < 100 && startCount - base < 2; i++) idle(1);
    idle(20);
    check("tx_count", startCount - base, 2);
    check("tx_data0", startData[base], 8'h48);
    check("tx_data1", startData[base + 1], 8'h49);
    check("tx_gap", startCyc[base + 1] - startCyc[base], 13);
    rd(3); check("tx_done_dspcr", bus.dout, 8'h80);

    // Transmitter that never goes busy: timeout after 4 cycles
    mode = 1; base = startCount;
    wr(8'h41); wr(8'h42);
    for (int i = 0; i < 60 && startCount - base < 2; i++) idle(1);
    idle(10);
    check("to_count", startCount - base, 2);
    check("to_data0", startData[base], 8'h41);
    check("to_data1", startData[base + 1], 8'h42);
    check("to_gap", startCyc[base + 1] - startCyc[base], 5);
    rd(3); check("to_dspcr", bus.dout, 8'h80);

    // Stuck busy: TX FIFO fills, 17th write dropped
    mode = 2; base = startCount;
    for (int i = 0; i < 17; i++) wr(8'h80 | 8'(i));
    rd(2); check("txfull_dsp", bus.dout, 8'h80);
    rd(3); check("txfull_dspcr", bus.dout, 8'h00);
    check("txfull_nostart", startCount - base, 0);
    mode = 0;
    for (int i = 0; i < 400 && startCount - base < 16; i++) idle(1);
    idle(30);
    check("txfull_count", startCount - base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("txfull_data%0d", i), startData[base + i], 8'(i));
    rd(2); check("txfull_dsp_after", bus.dout, 8'h00);
    rd(3); check("txfull_dspcr_after", bus.dout, 8'h80);

    // Reset mid-activity discards both FIFOs and the overflow flag
    mode = 2; base = startCount;
    wr(8'h11); wr(8'h12);
    for (int i = 0; i < 17; i++) rx(8'h20 + 8'(i));
    doReset();
    mode = 0;
    check("rst_dout", bus.dout, 8'h00);
    idle(30);
    check("rst_no_start", startCount - base, 0);
    rd(1); check("rst_kbdcr", bus.dout, 8'h00);
    rd(0); check("rst_kbd", bus.dout, 8'h80);
    rd(3); check("rst_dspcr", bus.dout, 8'h80);

    check("start_while_busy", busyViol, 0);
    check("start_width", wideViol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_host_bridge.md
Name: uart_host_bridge

Overview:
- CPU-side endpoint for the UART receiver/transmitter pair: consumes receiver output and drives transmitter start/data.
- Buffers received bytes in an RX FIFO and exposes them as an Apple-1-style keyboard data/status register pair.
- Buffers CPU display writes in a TX FIFO and drains them into the transmitter with a start/busy handshake.
- Sits between the UART pair and the 6502 bus decode, in place of a PIA keyboard/display port.

Parameters:
RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries)
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
cs  in  1  bus select, one-cycle strobe per access
we  in  1  1 = write, 0 = read (qualified by cs)
address  in  2  register select: 0 KBD, 1 KBDCR, 2 DSP, 3 DSPCR
din  in  8  write data
dout  out  8  registered read data
rx_data_ready  in  1  one-cycle strobe from receiver
rx_data  in  8  received byte, valid with rx_data_ready
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to send, held stable while tx_start is high
tx_busy  in  1  transmitter busy

Behaviour:
- Reset state: dout=0, tx_start=0, tx_data=0, both FIFOs empty, overflow flag=0, drain FSM in IDLE.
- Reset asserted mid-frame aborts all activity; FIFO contents are discarded.
- RX push: on rx_data_ready, write rx_data to the RX FIFO if not full.
  - If full, drop the byte and set the sticky overflow flag.
  - Push and pop in the same cycle are both performed. When the FIFO is full, the same-cycle pop frees the slot and the push is accepted.
- Reads: cs&~we updates dout at the next clk edge (1-cycle latency). dout holds its value otherwise.
  - addr0 (KBD): dout = {1, head[6:0]}; pops the RX FIFO. Reading while empty returns 8'h80 and does not pop.
  - addr1 (KBDCR): dout = {rx_not_empty, overflow, 6'b0}; the read clears overflow. An overflow event in the same cycle wins, so the flag stays set.
  - addr2 (DSP): dout = {tx_full, 7'b0}.
  - addr3 (DSPCR): dout = {tx_idle, 7'b0}. tx_idle = TX FIFO empty and FSM in IDLE.
- Writes: cs&we.
  - addr2: push {0, din[6:0]} into the TX FIFO. If the FIFO is full, drop the byte (no flag).
  - Other addresses: ignored.
- Drain FSM:
  - IDLE: when TX FIFO is non-empty and tx_busy=0, register tx_data=head, assert tx_start for exactly 1 cycle, pop, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1 (rises one cycle after start), then go to WAIT_DONE. Timeout: after 4 cycles without busy, return to IDLE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - Throughput: there is at least one IDLE cycle between bytes.
- FIFO pointers are RX/TX_DEPTH_LOG2 bits wide and wrap naturally. Count is (LOG2+1) bits, so full = count==DEPTH.

Optional Feature:
- Macro: UART_BRIDGE_UPPERCASE_EN.
- Defined: bytes 8'h61..8'h7A are converted to 8'h41..8'h5A at RX push. All other values pass unchanged.
- Undefined: bytes are stored exactly as received.
- Status bits and the overflow flag are unaffected either way.

Decomposition:
- Shared package uart_bridge_pkg:
  - Address constants ADDR_KBD/ADDR_KBDCR/ADDR_DSP/ADDR_DSPCR.
  - Drain FSM state enum (IDLE, WAIT_BUSY, WAIT_DONE).
  - Busy timeout constant (4).
- One sub-module: sync_fifo, parameterised by width and depth log2.
  - Ports: push, pop, wdata, rdata (head, combinational), empty, full.
  - Instantiated twice.

Test Plan:
- Reset, then read addr1 and addr3 -> dout 8'h00 then 8'h80; tx_start never pulses.
- rx_data_ready with 8'h41, then read addr1, addr0, addr1 -> 8'h80, 8'hC1, 8'h00.
- Push 17 RX bytes 8'h30..8'h40 with no reads, then read addr1 -> 8'hC0. A second addr1 read -> 8'h80. 16 addr0 reads return 8'hB0..8'hBF (bit7 set); the 17th byte (8'h40) was dropped.
- Write 8'hC8 then 8'h49 to addr2 with a transmitter model (busy for 10 cycles, rising 1 cycle after start):
  - tx_start pulses twice, with tx_data 8'h48 then 8'h49.
  - Second pulse occurs only after busy falls.
  - addr3 reads 8'h80 once both are done.
- Transmitter model never asserts busy -> FSM times out after 4 cycles and sends the next queued byte.
- With UART_BRIDGE_UPPERCASE_EN defined, rx 8'h7A -> KBD read 8'hDA; without it -> 8'hFA.
